axi_lite_regs_slv: RTL and testbench



---
 rtl/axi_lite_regs_slv.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_regs_slv.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regs_slv.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regs_slv (with default struct package axi_lite_regs_pkg)
// Purpose  : AXI4-Lite register-bank slave. It holds NoRegs data-width
//            registers and supports byte-strobe writes, per-register bus
//            read-only protection and a hardware load path for status fields.
// Ports    : clk_i, rst_i          - clock, asynchronous active-high reset
//            axi_lite_req_i        - AW/W/B-ready/AR/R-ready from the master
//            axi_lite_rsp_o        - AW/W/AR ready, B and R channels
//            reg_q_o               - current register values
//            reg_load_i, reg_d_i   - hardware load enable / data per register
//            wr_pulse_o            - one-cycle pulse per committed bus write
// Revision : 1.0 - initial release
// ============================================================================

package axi_lite_regs_pkg;
  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } rsp_t;
endpackage

module axi_lite_regs_slv #(
  parameter int unsigned                          NoRegs    = 8,
  parameter int unsigned                          AddrWidth = 32,
  parameter int unsigned                          DataWidth = 32,
  parameter logic [AddrWidth-1:0]                 BaseAddr  = '0,
  parameter logic [NoRegs-1:0]                    ReadOnly  = '0,
  parameter logic [NoRegs-1:0][DataWidth-1:0]     RegRstVal = '0,
  parameter type axi_lite_req_t = axi_lite_regs_pkg::req_t,
  parameter type axi_lite_rsp_t = axi_lite_regs_pkg::rsp_t
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  axi_lite_req_t                     axi_lite_req_i,
  output axi_lite_rsp_t                     axi_lite_rsp_o,
  output logic [NoRegs-1:0][DataWidth-1:0]  reg_q_o,
  input  logic [NoRegs-1:0]                 reg_load_i,
  input  logic [NoRegs-1:0][DataWidth-1:0]  reg_d_i,
  output logic [NoRegs-1:0]                 wr_pulse_o
);

  localparam int          StrbWidth  = DataWidth / 8;
  localparam int          AddrLsb    = $clog2(StrbWidth);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  // Register index of an address; only meaningful when the address decodes
  // in range (the subtraction wraps for addresses below BaseAddr).
  function automatic logic [AddrWidth-1:0] reg_idx(input logic [AddrWidth-1:0] a);
    return (a - BaseAddr) >> AddrLsb;
  endfunction

  function automatic logic in_range(input logic [AddrWidth-1:0] a);
    return (a >= BaseAddr) && (reg_idx(a) < AddrWidth'(NoRegs));
  endfunction

  logic                             aw_full_q, aw_full_d;
  logic [AddrWidth-1:0]             aw_addr_q, aw_addr_d;
  logic                             w_full_q,  w_full_d;
  logic [DataWidth-1:0]             w_data_q,  w_data_d;
  logic [StrbWidth-1:0]             w_strb_q,  w_strb_d;
  logic                             b_valid_q, b_valid_d;
  logic [1:0]                       b_resp_q,  b_resp_d;
  logic                             r_valid_q, r_valid_d;
  logic [DataWidth-1:0]             r_data_q,  r_data_d;
  logic [1:0]                       r_resp_q,  r_resp_d;
  logic [NoRegs-1:0][DataWidth-1:0] reg_q,     reg_d;

  logic                  aw_ready, w_ready, ar_ready;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [NoRegs-1:0]     wr_hit, rd_hit;
  logic                  wr_ok, rd_ok;
  logic [DataWidth-1:0]  rd_data;

  // Readies are forced low while reset is asserted so nothing is accepted
  // during an asynchronous reset window.
  assign aw_ready = !rst_i && !aw_full_q;
  assign w_ready  = !rst_i && !w_full_q;
  assign ar_ready = !rst_i && !r_valid_q;

  assign aw_hs  = axi_lite_req_i.aw_valid && aw_ready;
  assign w_hs   = axi_lite_req_i.w_valid  && w_ready;
  assign ar_hs  = axi_lite_req_i.ar_valid && ar_ready;
  assign commit = aw_full_q && w_full_q && (!b_valid_q || axi_lite_req_i.b_ready);

  // Address decode for the held write and the incoming read.
  always_comb begin
    wr_hit  = '0;
    rd_hit  = '0;
    rd_data = '0;
    for (int k = 0; k < NoRegs; k++) begin
      wr_hit[k] = in_range(aw_addr_q) && (reg_idx(aw_addr_q) == AddrWidth'(k));
      rd_hit[k] = in_range(axi_lite_req_i.ar_addr) &&
                  (reg_idx(axi_lite_req_i.ar_addr) == AddrWidth'(k));
      if (rd_hit[k]) rd_data = reg_q[k];
    end
    wr_ok = |(wr_hit & ~ReadOnly);
    rd_ok = |rd_hit;
  end

  // Register bank: bus write first, hardware load applied last so it wins
  // a same-cycle collision (the bus write is then silently dropped).
  always_comb begin
    reg_d      = reg_q;
    wr_pulse_o = '0;
    for (int k = 0; k < NoRegs; k++) begin
      wr_pulse_o[k] = commit && wr_hit[k] && !ReadOnly[k];
      if (wr_pulse_o[k]) begin
        for (int b = 0; b < StrbWidth; b++) begin
          if (w_strb_q[b]) reg_d[k][8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
      if (reg_load_i[k]) reg_d[k] = reg_d_i[k];
    end
  end

  // Channel state next-state logic.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = axi_lite_req_i.aw_addr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = axi_lite_req_i.w_data;
      w_strb_d = axi_lite_req_i.w_strb;
    end
    if (b_valid_q && axi_lite_req_i.b_ready) b_valid_d = 1'b0;
    // A commit may coincide with the B handshake; the new response replaces it.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = wr_ok ? RespOkay : RespSlvErr;
    end

    if (r_valid_q && axi_lite_req_i.r_ready) r_valid_d = 1'b0;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_ok ? rd_data : '0;
      r_resp_d  = rd_ok ? RespOkay : RespSlvErr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      reg_q     <= RegRstVal;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      reg_q     <= reg_d;
    end
  end

  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = aw_ready;
    axi_lite_rsp_o.w_ready  = w_ready;
    axi_lite_rsp_o.b_valid  = b_valid_q;
    axi_lite_rsp_o.b_resp   = b_resp_q;
    axi_lite_rsp_o.ar_ready = ar_ready;
    axi_lite_rsp_o.r_valid  = r_valid_q;
    axi_lite_rsp_o.r_data   = r_data_q;
    axi_lite_rsp_o.r_resp   = r_resp_q;
  end

  assign reg_q_o = reg_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regs_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regs_slv
// Purpose  : Directed self-checking bench for axi_lite_regs_slv: reset values,
//            write/read, strobes, protection and decode, channel ordering with
//            B backpressure, load collision and mid-transaction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regs_slv;
  import axi_lite_regs_pkg::*;

  localparam int unsigned           NoRegs = 8;
  localparam logic [31:0]           Base   = 32'h0000_0100;
  localparam logic [NoRegs-1:0]     RoMask = 8'b1000_0000;
  localparam logic [NoRegs-1:0][31:0] RstVal = {32'h0000_0005, {7{32'h0}}};

  logic                          clk = 1'b0;
  logic                          rst_i;
  req_t                          req;
  rsp_t                          rsp;
  logic [NoRegs-1:0][31:0]       reg_q;
  logic [NoRegs-1:0]             reg_load;
  logic [NoRegs-1:0][31:0]       reg_din;
  logic [NoRegs-1:0]             wr_pulse;

  int checks = 0;
  int errors = 0;

  axi_lite_regs_slv #(
    .NoRegs(NoRegs), .AddrWidth(32), .DataWidth(32), .BaseAddr(Base),
    .ReadOnly(RoMask), .RegRstVal(RstVal),
    .axi_lite_req_t(req_t), .axi_lite_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .axi_lite_req_i(req), .axi_lite_rsp_o(rsp),
    .reg_q_o(reg_q), .reg_load_i(reg_load), .reg_d_i(reg_din), .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full write: AW+W offered together, B accepted immediately.
  // lat = edges after the last address/data handshake until b_valid is seen.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NoRegs-1:0] pulses, output int lat);
    int  n;
    logic aw_hs, w_hs;
    pulses = '0;
    req.aw_addr = addr; req.aw_valid = 1'b1;
    req.w_data  = data; req.w_strb = strb; req.w_valid = 1'b1;
    req.b_ready = 1'b1;
    n = 0;
    while ((req.aw_valid || req.w_valid) && n < 20) begin
      aw_hs = req.aw_valid && rsp.aw_ready;
      w_hs  = req.w_valid && rsp.w_ready;
      tick();
      if (aw_hs) req.aw_valid = 1'b0;
      if (w_hs)  req.w_valid  = 1'b0;
      n++;
    end
    n = 0;
    while (!rsp.b_valid && n < 20) begin
      pulses |= wr_pulse;
      tick();
      n++;
    end
    check("write_b_valid_seen", {63'd0, rsp.b_valid}, 64'd1);
    lat  = n;
    resp = rsp.b_resp;
    tick();
  endtask

  // Full read; lat = edges after the AR handshake until r_valid is seen.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int  n;
    logic hs;
    req.ar_addr = addr; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    n = 0;
    while (req.ar_valid && n < 20) begin
      hs = rsp.ar_ready;
      tick();
      if (hs) req.ar_valid = 1'b0;
      n++;
    end
    n = 0;
    while (!rsp.r_valid && n < 20) begin
      tick();
      n++;
    end
    check("read_r_valid_seen", {63'd0, rsp.r_valid}, 64'd1);
    lat  = n;
    data = rsp.r_data;
    resp = rsp.r_resp;
    tick();
  endtask

  initial begin
    logic [1:0]        resp;
    logic [NoRegs-1:0] pulses;
    logic [31:0]       data;
    int                lat;

    req = '0; req.b_ready = 1'b1; req.r_ready = 1'b1;
    reg_load = '0; reg_din = '0;
    rst_i = 1'b1;
    tick(); tick();

    // ---- Reset state ----
    check("rst_aw_ready", {63'd0, rsp.aw_ready}, 64'd0);
    check("rst_ar_ready", {63'd0, rsp.ar_ready}, 64'd0);
    check("rst_reg7", {32'd0, reg_q[7]}, 64'h5);
    check("rst_reg1", {32'd0, reg_q[1]}, 64'h0);
    rst_i = 1'b0;
    #1;
    check("post_rst_aw_ready", {63'd0, rsp.aw_ready}, 64'd1);
    tick();

    // ---- Basic write / read ----
    bus_write(Base + 32'h4, 32'hDEAD_BEEF, 4'hF, resp, pulses, lat);
    check("wr1_resp", {62'd0, resp}, 64'd0);
    check("wr1_pulse", {56'd0, pulses}, 64'h02);
    check("wr1_latency", 64'(lat), 64'd1);
    check("wr1_reg1", {32'd0, reg_q[1]}, 64'hDEAD_BEEF);
    bus_read(Base + 32'h4, data, resp, lat);
    check("rd1_data", {32'd0, data}, 64'hDEAD_BEEF);
    check("rd1_resp", {62'd0, resp}, 64'd0);
    check("rd1_latency", 64'(lat), 64'd0);

    // ---- Strobes ----
    bus_write(Base + 32'h8, 32'h1122_3344, 4'hF, resp, pulses, lat);
    bus_write(Base + 32'h8, 32'hAABB_CCDD, 4'h5, resp, pulses, lat);
    check("strb_reg2", {32'd0, reg_q[2]}, 64'h11BB_33DD);

    // ---- Protection / decode ----
    bus_write(Base + 32'h1C, 32'hFFFF_FFFF, 4'hF, resp, pulses, lat);
    check("ro_resp", {62'd0, resp}, 64'd2);
    check("ro_pulse", {56'd0, pulses}, 64'h00);
    check("ro_reg7", {32'd0, reg_q[7]}, 64'h5);
    bus_read(Base + 32'h1C, data, resp, lat);
    check("ro_rd_data", {32'd0, data}, 64'h5);
    check("ro_rd_resp", {62'd0, resp}, 64'd0);
    bus_read(Base + 32'h20, data, resp, lat);
    check("oor_rd_resp", {62'd0, resp}, 64'd2);
    check("oor_rd_data", {32'd0, data}, 64'h0);
    bus_write(Base - 32'h40, 32'h1234_5678, 4'hF, resp, pulses, lat);
    check("below_wr_resp", {62'd0, resp}, 64'd2);
    check("below_wr_pulse", {56'd0, pulses}, 64'h00);

    // ---- Channel ordering / B backpressure ----
    req.b_ready = 1'b0;
    req.w_data = 32'h0000_0055; req.w_strb = 4'hF; req.w_valid = 1'b1;
    tick();
    req.w_valid = 1'b0;
    tick(); tick();
    check("ord_no_commit_w_only", {56'd0, wr_pulse}, 64'h00);
    req.aw_addr = Base + 32'hC; req.aw_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0;
    check("ord_commit_pulse", {56'd0, wr_pulse}, 64'h08);
    tick();
    check("ord_b_valid", {63'd0, rsp.b_valid}, 64'd1);
    check("ord_reg3", {32'd0, reg_q[3]}, 64'h55);
    // second pair accepted into empty holding registers while B stalls
    req.aw_addr = Base + 32'hC; req.aw_valid = 1'b1;
    req.w_data = 32'h0000_0066; req.w_valid = 1'b1;
    check("ord_aw_ready2", {63'd0, rsp.aw_ready}, 64'd1);
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    tick(); tick();
    check("ord_b_held", {63'd0, rsp.b_valid}, 64'd1);
    check("ord_b_resp_held", {62'd0, rsp.b_resp}, 64'd0);
    check("ord_no_second_commit", {56'd0, wr_pulse}, 64'h00);
    check("ord_reg3_held", {32'd0, reg_q[3]}, 64'h55);
    check("ord_aw_blocked", {63'd0, rsp.aw_ready}, 64'd0);
    req.b_ready = 1'b1;
    #1;
    check("ord_second_pulse", {56'd0, wr_pulse}, 64'h08);
    tick();
    check("ord_second_b_valid", {63'd0, rsp.b_valid}, 64'd1);
    check("ord_reg3_second", {32'd0, reg_q[3]}, 64'h66);
    tick();
    check("ord_b_drained", {63'd0, rsp.b_valid}, 64'd0);

    // ---- Hardware load collision ----
    req.aw_addr = Base; req.aw_valid = 1'b1;
    req.w_data = 32'h0000_00FF; req.w_strb = 4'hF; req.w_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    reg_load[0] = 1'b1; reg_din[0] = 32'h1;
    check("coll_pulse", {56'd0, wr_pulse}, 64'h01);
    tick();
    reg_load[0] = 1'b0;
    check("coll_reg0", {32'd0, reg_q[0]}, 64'h1);
    check("coll_b_valid", {63'd0, rsp.b_valid}, 64'd1);
    check("coll_b_resp", {62'd0, rsp.b_resp}, 64'd0);
    tick();

    // ---- Mid-transaction reset ----
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    req.aw_addr = Base + 32'h4; req.aw_valid = 1'b1;
    req.w_data = 32'h1234_5678; req.w_valid = 1'b1;
    req.ar_addr = Base + 32'h4; req.ar_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    tick();
    check("mr_b_pending", {63'd0, rsp.b_valid}, 64'd1);
    check("mr_r_pending", {63'd0, rsp.r_valid}, 64'd1);
    rst_i = 1'b1;
    #1;
    check("mr_b_cleared", {63'd0, rsp.b_valid}, 64'd0);
    check("mr_r_cleared", {63'd0, rsp.r_valid}, 64'd0);
    check("mr_r_data", {32'd0, rsp.r_data}, 64'h0);
    check("mr_reg1", {32'd0, reg_q[1]}, 64'h0);
    check("mr_reg3", {32'd0, reg_q[3]}, 64'h0);
    check("mr_reg7", {32'd0, reg_q[7]}, 64'h5);
    check("mr_w_ready", {63'd0, rsp.w_ready}, 64'd0);
    check("mr_ar_ready", {63'd0, rsp.ar_ready}, 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("mr_aw_ready_after", {63'd0, rsp.aw_ready}, 64'd1);
    check("mr_ar_ready_after", {63'd0, rsp.ar_ready}, 64'd1);
    check("mr_no_b_after", {63'd0, rsp.b_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
